actuator_dac_driver: RTL and testbench
======================================

// Module: actuator_dac_driver
// PURPOSE
// - Consumes the PID stage's signed 16-bit control word and valid strobe.
// - Converts the word to a unipolar offset-binary DAC code and applies a per-frame slew limit.
// - Shifts each result to the deformable-mirror actuator DAC as a 24-bit SPI frame (mode 0).
// - Sits directly downstream of the PID controller.
// PARAMETERS
// - CLK_DIV   4      clk cycles per SCLK half-period (>=1)
// - CS_GAP    2      clk cycles cs_n held high after a frame, before done
// - SLEW_MAX  1024   max |code change| per frame, in LSBs (1..65535)
// - DAC_CMD   8'h30  8-bit command prefix (write-and-update)
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   synchronous, active-low reset
// - in_valid   in   1   1-cycle strobe: in_data is a new sample
// - in_data    in   16  signed control word (two's complement)
// - busy       out  1   frame in progress or pending sample queued
// - done       out  1   1-cycle pulse after a frame completes
// - last_code  out  16  offset-binary code of the last completed frame
// - drop_cnt   out  8   saturating count of overwritten pending samples
// - dac_cs_n   out  1   SPI chip select, active low
// - dac_sclk   out  1   SPI clock, idles low
// - dac_mosi   out  1   SPI data, MSB first
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n sampled on posedge clk).
// - Reset values:
//   - busy=0, done=0, last_code=16'h8000 (midscale), drop_cnt=0.
//   - dac_cs_n=1, dac_sclk=0, dac_mosi=0.
//   - Pending slot empty; FSM in IDLE.
// - Code conversion: target = in_data ^ 16'h8000 (-32768 -> 0x0000, 0 -> 0x8000, 32767 -> 0xFFFF).
// - Slew limit, computed in the LOAD cycle with 17-bit signed arithmetic:
//   - delta = target - last_code.
//   - Clamp delta to [-SLEW_MAX, +SLEW_MAX].
//   - code = last_code + delta; the result always stays within 0..65535, so no wrap.
// - Input acceptance (there is no ready signal):
//   - in_valid is always accepted into a 1-deep pending slot.
//   - If the slot is already full, it is overwritten and drop_cnt increments (saturates at 255).
// - FSM states: IDLE -> LOAD -> SHIFT -> GAP -> DONE -> IDLE.
//   - IDLE: if pending is full, go to LOAD and clear pending.
//   - LOAD (1 cycle): latch frame = {DAC_CMD, code}; dac_cs_n<=0; dac_mosi<=frame[23].
//   - SHIFT: 24 bits. Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
//     - mosi changes only while sclk is low.
//     - The DAC samples mosi on the sclk rising edge.
//     - After bit 0's high phase: sclk<=0, cs_n<=1.
//   - GAP: CS_GAP cycles with cs_n high.
//   - DONE (1 cycle): done=1; last_code<=code.
// - Latency: in_valid in IDLE -> cs_n low 2 cycles later (pending, then LOAD).
//   - in_valid -> done = 2 + 48*CLK_DIV + CS_GAP cycles (196 at defaults).
// - busy=1 whenever the FSM is not in IDLE or the pending slot is full.
// - Simultaneous events:
//   - in_valid during the DONE cycle is captured to pending; LOAD follows after one IDLE cycle.
//   - in_valid while pending is being consumed (IDLE->LOAD) refills pending, with no drop.
// - Reset mid-frame: on the next posedge all outputs return to reset values, the frame is
//   abandoned, last_code is reset to 0x8000, and pending is cleared.
// CONFIGURATION
// - Macro: DAC_SLEW_LIMIT_EN.
// - Defined: slew limit applied as above; SLEW_MAX is used.
// - Undefined: code = target directly; the limiter logic is not compiled in; SLEW_MAX is ignored.
//   Frame timing is identical in both builds.
// TESTING
// - Reset: hold rst_n=0 for 3 cycles -> cs_n=1, sclk=0, busy=0, last_code=0x8000, drop_cnt=0.
// - Midscale: in_data=0 -> one frame 0x308000 captured on sclk rising edges; done 196 cycles
//   after in_valid; last_code=0x8000.
// - Slew (EN defined): in_data=32767 -> frames 0x308400, 0x308800 on repeat.
//   - Undefined build: frame 0x30FFFF.
// - Negative step (EN defined): from reset, in_data=-32768 -> frame 0x307C00; last_code=0x7C00.
// - Overrun: three in_valid pulses mid-frame with values 10, 20, 30 -> drop_cnt=2; next frame
//   carries the sample 30.
// - Reset at bit 12 of a frame -> cs_n=1 next cycle; no done pulse; a new in_valid starts a
//   clean 24-bit frame.

Source files
------------

// File: rtl/actuator_dac_driver.sv
`default_nettype none
// ============================================================================
// Module   : actuator_dac_driver
// Purpose  : PID word -> offset-binary DAC code (optional slew limit, macro
//            DAC_SLEW_LIMIT_EN) -> 24-bit mode-0 SPI frame to the mirror DAC.
// Revision : 1.0  initial release
// ============================================================================
module actuator_dac_driver #(
  parameter int          CLK_DIV  = 4,
  parameter int          CS_GAP   = 2,
  parameter int          SLEW_MAX = 1024,
  parameter logic [7:0]  DAC_CMD  = 8'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] last_code,
  output logic [7:0]  drop_cnt,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [15:0] C_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] C_GAP_LAST = 16'((CS_GAP > 0) ? (CS_GAP - 1) : 0);
  localparam logic [4:0]  C_BIT_LAST = 5'd23;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("actuator_dac_driver: CLK_DIV must be >= 1");
  end
  if (SLEW_MAX < 1 || SLEW_MAX > 65535) begin : g_bad_slew_max
    $error("actuator_dac_driver: SLEW_MAX must be in 1..65535");
  end

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [15:0] pdata_q, pdata_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] code_q, code_d;
  logic [23:0] frame_q, frame_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] last_code_q, last_code_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;

  logic [15:0] target;
  logic [15:0] new_code;
  logic        consume;

  assign target = sample_q ^ 16'h8000;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic signed [16:0] C_SLEW_POS = 17'(SLEW_MAX);
  localparam logic signed [16:0] C_SLEW_NEG = -17'(SLEW_MAX);

  logic signed [16:0] delta;
  logic signed [16:0] delta_lim;
  logic signed [16:0] code_sum;

  // Both operands are unsigned 16-bit, so a 17-bit signed difference cannot overflow.
  always_comb begin
    delta = $signed({1'b0, target}) - $signed({1'b0, last_code_q});
    if (delta > C_SLEW_POS) begin
      delta_lim = C_SLEW_POS;
    end else if (delta < C_SLEW_NEG) begin
      delta_lim = C_SLEW_NEG;
    end else begin
      delta_lim = delta;
    end
    code_sum = $signed({1'b0, last_code_q}) + delta_lim;
    new_code = code_sum[15:0];
  end
`else
  assign new_code = target;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pdata_d     = pdata_q;
    sample_d    = sample_q;
    code_d      = code_q;
    frame_d     = frame_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    last_code_d = last_code_q;
    drop_cnt_d  = drop_cnt_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;

    // A strobe coinciding with the IDLE->LOAD hand-off refills the slot without a drop.
    consume = (state_q == S_IDLE) && pending_q;
    if (consume) begin
      pending_d = 1'b0;
    end
    if (in_valid) begin
      pending_d = 1'b1;
      pdata_d   = in_data;
      if (pending_q && !consume && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          sample_d = pdata_q;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        code_d    = new_code;
        frame_d   = {DAC_CMD[6:0], new_code, 1'b0};
        mosi_d    = DAC_CMD[7];
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt_q == C_DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == C_BIT_LAST) begin
              cs_n_d    = 1'b1;
              mosi_d    = 1'b0;
              gap_cnt_d = '0;
              if (CS_GAP > 0) begin
                state_d = S_GAP;
              end else begin
                state_d     = S_DONE;
                done_d      = 1'b1;
                last_code_d = code_q;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              mosi_d    = frame_q[23];
              frame_d   = {frame_q[22:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == C_GAP_LAST) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          last_code_d = code_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) || pending_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      pdata_q     <= '0;
      sample_q    <= '0;
      code_q      <= 16'h8000;
      frame_q     <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_code_q <= 16'h8000;
      drop_cnt_q  <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pdata_q     <= pdata_d;
      sample_q    <= sample_d;
      code_q      <= code_d;
      frame_q     <= frame_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_code_q <= last_code_d;
      drop_cnt_q  <= drop_cnt_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign last_code = last_code_q;
  assign drop_cnt  = drop_cnt_q;
  assign dac_cs_n  = cs_n_q;
  assign dac_sclk  = sclk_q;
  assign dac_mosi  = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_actuator_dac_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_actuator_dac_driver
// Purpose  : Directed self-checking bench; SPI frames are rebuilt from the pins.
// Revision : 1.0  initial release
// ============================================================================
module tb_actuator_dac_driver;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int LAT     = 2 + 48 * CLK_DIV + CS_GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] last_code;
  logic [7:0]  drop_cnt;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [23:0] cap = '0;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic [23:0] EXP_POS1 = 24'h308400;
  localparam logic [23:0] EXP_POS2 = 24'h308800;
  localparam logic [23:0] EXP_NEG  = 24'h307C00;
  localparam logic [15:0] EXP_NEGL = 16'h7C00;
`else
  localparam logic [23:0] EXP_POS1 = 24'h30FFFF;
  localparam logic [23:0] EXP_POS2 = 24'h30FFFF;
  localparam logic [23:0] EXP_NEG  = 24'h300000;
  localparam logic [15:0] EXP_NEGL = 16'h0000;
`endif

  actuator_dac_driver #(
    .CLK_DIV  (CLK_DIV),
    .CS_GAP   (CS_GAP),
    .SLEW_MAX (1024),
    .DAC_CMD  (8'h30)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .last_code (last_code),
    .drop_cnt  (drop_cnt),
    .dac_cs_n  (dac_cs_n),
    .dac_sclk  (dac_sclk),
    .dac_mosi  (dac_mosi)
  );

  always #5 clk = ~clk;

  // The DAC's view: shift mosi in on every sclk rise while selected.
  always @(posedge dac_sclk) begin
    if (!dac_cs_n) begin
      cap   = {cap[22:0], dac_mosi};
      edges = edges + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles after the sampling edge until done / first cs_n low (0 = never seen).
  task automatic wait_done(output int n_done, output int n_cs);
    n_done = 0;
    n_cs   = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (!dac_cs_n && n_cs == 0) n_cs = n;
      if (done) begin
        n_done = n;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int nd;
    int nc;
    int e0;
    int ndone;
    bit reached;

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", 32'(dac_cs_n), 32'h1);
    chk("rst_sclk", 32'(dac_sclk), 32'h0);
    chk("rst_mosi", 32'(dac_mosi), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_last", 32'(last_code), 32'h8000);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Midscale
    e0 = edges;
    send(16'h0000);
    wait_done(nd, nc);
    chk("mid_latency", 32'(nd), 32'(LAT));
    chk("mid_cs_latency", 32'(nc), 32'd2);
    chk("mid_frame", 32'(cap), 32'h308000);
    chk("mid_bits", 32'(edges - e0), 32'd24);
    chk("mid_last", 32'(last_code), 32'h8000);
    chk("mid_busy_done", 32'(busy), 32'h1);
    chk("mid_cs_high", 32'(dac_cs_n), 32'h1);
    tick();
    chk("mid_done_pulse", 32'(done), 32'h0);
    chk("mid_idle_busy", 32'(busy), 32'h0);

    // Full-scale positive step, twice
    send(16'h7FFF);
    wait_done(nd, nc);
    chk("pos1_frame", 32'(cap), 32'(EXP_POS1));
    chk("pos1_last", 32'(last_code), 32'(EXP_POS1[15:0]));
    send(16'h7FFF);
    wait_done(nd, nc);
    chk("pos2_frame", 32'(cap), 32'(EXP_POS2));
    chk("pos2_last", 32'(last_code), 32'(EXP_POS2[15:0]));

    // Negative full-scale step from reset
    do_reset();
    send(16'h8000);
    wait_done(nd, nc);
    chk("neg_latency", 32'(nd), 32'(LAT));
    chk("neg_frame", 32'(cap), 32'(EXP_NEG));
    chk("neg_last", 32'(last_code), 32'(EXP_NEGL));

    // Overrun: three strobes while a frame is shifting
    do_reset();
    send(16'd5);
    repeat (50) tick();
    send(16'd10);
    repeat (3) tick();
    send(16'd20);
    tick();
    send(16'd30);
    chk("ovr_drop", 32'(drop_cnt), 32'd2);
    chk("ovr_busy", 32'(busy), 32'h1);
    wait_done(nd, nc);
    chk("ovr_frame1", 32'(cap), 32'h308005);
    e0 = edges;
    wait_done(nd, nc);
    chk("ovr_frame2_seen", 32'(nd != 0), 32'h1);
    chk("ovr_frame2", 32'(cap), 32'h30801E);
    chk("ovr_bits2", 32'(edges - e0), 32'd24);
    chk("ovr_last", 32'(last_code), 32'h801E);
    chk("ovr_drop_hold", 32'(drop_cnt), 32'd2);

    // Reset at bit 12, then a clean frame
    send(16'h0100);
    e0 = edges;
    reached = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (edges - e0 >= 12) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_rst_reached_bit12", 32'(reached), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cs_n", 32'(dac_cs_n), 32'h1);
    chk("mid_rst_sclk", 32'(dac_sclk), 32'h0);
    chk("mid_rst_mosi", 32'(dac_mosi), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_last", 32'(last_code), 32'h8000);
    chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 250; n++) begin
      tick();
      if (done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    chk("mid_rst_idle_cs", 32'(dac_cs_n), 32'h1);
    e0 = edges;
    send(16'h0100);
    wait_done(nd, nc);
    chk("clean_latency", 32'(nd), 32'(LAT));
    chk("clean_frame", 32'(cap), 32'h308100);
    chk("clean_bits", 32'(edges - e0), 32'd24);
    chk("clean_last", 32'(last_code), 32'h8100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
